fft_output_reorder: RTL and testbench

Output-end companion to the butterfly-stage controllers of the 32-point FFT. The final stage emits each frame in bit-reversed order. This block accepts that stream and re-emits every 32-sample frame in natural order (X[0]..X[31]), tagged with bin index and end-of-frame. It uses a ping-pong pair of 32-entry buffers, so back-to-back frames stream without gaps.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_output_reorder_if.sv | 32 +++
 rtl/reorder_bank.sv | 31 +++
 rtl/fft_output_reorder.sv | 117 +++++++++++
 tb/tb_fft_output_reorder.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_pkg
//  Purpose  : Shared constants, read-FSM state type and bit-reversal helper
//             for the 32-point FFT datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

  localparam int FFT_N     = 32;
  localparam int FFT_LOG2N = 5;
  localparam int FFT_WIDTH = 15;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_DRAIN = 1'b1
  } rd_state_t;

  function automatic logic [FFT_LOG2N-1:0] bitrev5(input logic [FFT_LOG2N-1:0] x);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_output_reorder_if.sv
`default_nettype none
// ============================================================================
//  Module   : fft_output_reorder_if
//  Purpose  : Bit-reversed input stream and natural-order output stream of
//             the FFT output reorder block.
//  Revision : 1.0 - initial release
// ============================================================================
interface fft_output_reorder_if
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH
);
  logic                       valid_i;
  logic signed [WIDTH-1:0]    data_in_r;
  logic signed [WIDTH-1:0]    data_in_i;
  logic                       valid_o;
  logic signed [WIDTH-1:0]    data_out_r;
  logic signed [WIDTH-1:0]    data_out_i;
  logic [FFT_LOG2N-1:0]       index_o;
  logic                       last_o;

  modport master (
    output valid_i, data_in_r, data_in_i,
    input  valid_o, data_out_r, data_out_i, index_o, last_o
  );

  modport slave (
    input  valid_i, data_in_r, data_in_i,
    output valid_o, data_out_r, data_out_i, index_o, last_o
  );
endinterface
`default_nettype wire

// File: rtl/reorder_bank.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_bank
//  Purpose  : 32-entry register array, synchronous write / combinational read.
//  Revision : 1.0 - initial release
// ============================================================================
module reorder_bank
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH
) (
  input  wire logic                   clk,
  input  wire logic                   we,
  input  wire logic [FFT_LOG2N-1:0]   waddr,
  input  wire logic [2*WIDTH-1:0]     wdata,
  input  wire logic [FFT_LOG2N-1:0]   raddr,
  output      logic [2*WIDTH-1:0]     rdata
);

  logic [2*WIDTH-1:0] r_mem [FFT_N];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fft_output_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : fft_output_reorder
//  Purpose  : Ping-pong reorder of bit-reversed FFT frames into natural order
//             with bin index and end-of-frame tagging.
//  Revision : 1.0 - initial release
// ============================================================================
module fft_output_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH,
  parameter int N     = FFT_N
) (
  input wire logic             clk,
  input wire logic             rst_n,
  fft_output_reorder_if.slave  bus
);

  localparam int                   c_word_w   = 2 * WIDTH;
  localparam logic [FFT_LOG2N-1:0] c_last_idx = FFT_LOG2N'(N - 1);

  logic [FFT_LOG2N-1:0]    r_wcnt;
  logic                    r_wbank;
  logic                    w_frame_ready;
  logic [FFT_LOG2N-1:0]    w_waddr;
  logic [c_word_w-1:0]     w_wdata;
  logic [c_word_w-1:0]     w_rdata [2];

  rd_state_t               r_state;
  logic                    r_rbank;
  logic [FFT_LOG2N-1:0]    r_rcnt;
  logic                    r_valid;
  logic signed [WIDTH-1:0] r_out_r;
  logic signed [WIDTH-1:0] r_out_i;
  logic [FFT_LOG2N-1:0]    r_index;
  logic                    r_last;

  assign w_frame_ready = bus.valid_i && (r_wcnt == c_last_idx);
  assign w_waddr       = bitrev5(r_wcnt);
  assign w_wdata       = {bus.data_in_r, bus.data_in_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt  <= '0;
      r_wbank <= 1'b0;
    end else if (bus.valid_i) begin
      r_wcnt <= r_wcnt + 1'b1;
      if (r_wcnt == c_last_idx) begin
        r_wbank <= ~r_wbank;
      end
    end
  end

  generate
    for (genvar g = 0; g < 2; g++) begin : g_bank
      reorder_bank #(.WIDTH(WIDTH)) u_bank (
        .clk   (clk),
        .we    (bus.valid_i && (r_wbank == 1'(g))),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .raddr (r_rcnt),
        .rdata (w_rdata[g])
      );
    end
  endgenerate

  // The reader trails the writer by exactly one bank, so it never touches the bank being filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_rbank <= 1'b0;
      r_rcnt  <= '0;
      r_valid <= 1'b0;
      r_out_r <= '0;
      r_out_i <= '0;
      r_index <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          if (w_frame_ready) begin
            r_rbank <= r_wbank;
            r_rcnt  <= '0;
            r_state <= R_DRAIN;
          end
        end
        R_DRAIN: begin
          r_valid            <= 1'b1;
          {r_out_r, r_out_i} <= w_rdata[r_rbank];
          r_index            <= r_rcnt;
          r_last             <= (r_rcnt == c_last_idx);
          if (r_rcnt == c_last_idx) begin
            r_rcnt <= '0;
            if (w_frame_ready) begin
              r_rbank <= r_wbank;
            end else begin
              r_state <= R_IDLE;
            end
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign bus.valid_o    = r_valid;
  assign bus.data_out_r = r_out_r;
  assign bus.data_out_i = r_out_i;
  assign bus.index_o    = r_index;
  assign bus.last_o     = r_last;

endmodule
`default_nettype wire

// File: tb/tb_fft_output_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_output_reorder
//  Purpose  : Scoreboard bench for the FFT output reorder block.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fft_output_reorder;
  import fft_pkg::*;

  typedef struct {
    int idx;
    int re;
    int im;
    int last;
  } exp_t;

  logic clk;
  logic rst_n;

  fft_output_reorder_if #(.WIDTH(15)) bus ();

  fft_output_reorder #(.WIDTH(15), .N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp;
  int   n_err;
  int   cyc;
  exp_t sb_q[$];
  int   m_re [32];
  int   m_im [32];
  int   m_cnt;
  int   accept_cyc;
  int   run_len;
  int   run_start;
  int   last_run;
  exp_t e;

  task automatic check(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
    end else if (bus.valid_o) begin
      if (run_len == 0) run_start = cyc;
      run_len++;
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("index", int'(bus.index_o), e.idx);
        check("data_r", int'(bus.data_out_r), e.re);
        check("data_i", int'(bus.data_out_i), e.im);
        check("last", int'(bus.last_o), e.last);
      end
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

  // One input cycle; the model files accepted samples at their bit-reversed bin.
  task automatic drive(input bit v, input int re, input int im);
    bus.valid_i   = v;
    bus.data_in_r = 15'(re);
    bus.data_in_i = 15'(im);
    @(posedge clk);
    #1;
    if (v && rst_n) begin
      m_re[int'(bitrev5(5'(m_cnt)))] = re;
      m_im[int'(bitrev5(5'(m_cnt)))] = im;
      if (m_cnt == 31) begin
        for (int k = 0; k < 32; k++)
          sb_q.push_back('{idx: k, re: m_re[k], im: m_im[k], last: (k == 31) ? 1 : 0});
        m_cnt      = 0;
        accept_cyc = cyc;
      end else begin
        m_cnt++;
      end
    end
    bus.valid_i = 1'b0;
  endtask

  // mode 0: ramp (re = base+bin, im = -re); mode 1: full-scale alternating extremes
  task automatic send_frame(input int base, input int mode, input bit gaps);
    int j;
    int c;
    int b;
    j = 0;
    c = 0;
    while (j < 32) begin
      if (gaps && (c % 3 == 2)) begin
        drive(1'b0, 0, 0);
      end else begin
        b = int'(bitrev5(5'(j)));
        if (mode == 0) drive(1'b1, base + b, -(base + b));
        else if (b % 2 == 0) drive(1'b1, 16383, -16384);
        else drive(1'b1, -16384, 16383);
        j++;
      end
      c++;
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("drain_done", sb_q.size(), 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; m_cnt = 0;
    run_len = 0; run_start = 0; last_run = 0; accept_cyc = 0;
    bus.valid_i = 1'b0; bus.data_in_r = '0; bus.data_in_i = '0;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.valid_i = k[0];
      @(negedge clk);
      check("rst_valid", int'(bus.valid_o), 0);
      check("rst_data", int'(bus.data_out_r) | int'(bus.data_out_i), 0);
      check("rst_index", int'(bus.index_o), 0);
      check("rst_last", int'(bus.last_o), 0);
    end
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    last_run = 0;
    send_frame(0, 0, 1'b0);
    wait_drain();
    check("single_run_len", last_run, 32);
    check("single_latency", run_start, accept_cyc + 1);

    last_run = 0;
    for (int f = 0; f < 3; f++) send_frame(100 * f, 0, 1'b0);
    wait_drain();
    check("b2b_run_len", last_run, 96);

    last_run = 0;
    send_frame(0, 0, 1'b1);
    wait_drain();
    check("gap_run_len", last_run, 32);
    check("gap_latency", run_start, accept_cyc + 1);

    send_frame(0, 1, 1'b0);
    wait_drain();

    for (int j = 0; j < 17; j++) drive(1'b1, 5000 + j, -5000 - j);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_cnt = 0;
    sb_q.delete();
    check("midrst_valid", int'(bus.valid_o), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    last_run = 0;
    send_frame(200, 0, 1'b0);
    wait_drain();
    check("midrst_run_len", last_run, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
